// File: rtl/a25_copro15_pkg.sv
// Shared types and constants for the Amber 25 extended CP15 block.
// Register numbers, flush FSM states and the fault entry layout.
package a25_copro15_pkg;

    localparam logic [3:0] CRN_ID         = 4'd0;
    localparam logic [3:0] CRN_FLUSH      = 4'd1;
    localparam logic [3:0] CRN_CACHE      = 4'd2;
    localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
    localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
    localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
    localparam logic [3:0] CRN_FSTATUS    = 4'd6;
    localparam logic [3:0] CRN_FADDR      = 4'd7;
    localparam logic [3:0] CRN_FPOP       = 4'd8;

    localparam logic [1:0] OP_MCR = 2'd2;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_BUSY,
        FL_GAP
    } flush_state_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [31:0] address;
    } fault_entry_t;

endpackage

// File: rtl/a25_fault_fifo.sv
// Fault record FIFO with sticky overflow.
// Depth need not be a power of two; pointers wrap explicitly.
module a25_fault_fifo
    import a25_copro15_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic [7:0]  i_status,
    input  logic [31:0] i_address,
    input  logic        i_pop,
    output logic [7:0]  o_head_status,
    output logic [31:0] o_head_address,
    output logic [3:0]  o_count,
    output logic        o_overflow
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [3:0]    FULL = 4'(DEPTH);

    fault_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    count;
    logic          overflow;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    fault_entry_t  head;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == 4'd0);
    assign full    = (count == FULL);
    assign do_pop  = i_pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign do_push = i_push && (!full || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{status: i_status, address: i_address};
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 4'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 4'd1;
            end
            if (i_pop) begin
                overflow <= 1'b0;
            end else if (i_push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head           = empty ? '0 : mem[rd_ptr];
    assign o_head_status  = head.status;
    assign o_head_address = head.address;
    assign o_count        = count;
    assign o_overflow     = overflow;

endmodule

// File: rtl/a25_copro15_ext.sv
// Extended CP15: cache control, region registers, fault FIFO,
// registered region lookup and flush request handshake.
module a25_copro15_ext
    import a25_copro15_pkg::*;
#(
    parameter int          REGION_BITS  = 5,
    parameter int          REGION_SHIFT = 21,
    parameter int          FAULT_DEPTH  = 4,
    parameter logic [31:0] ID_VALUE     = 32'h4156_0301
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_core_stall,
    input  logic [3:0]  i_copro_crn,
    input  logic [1:0]  i_copro_operation,
    input  logic [31:0] i_copro_write_data,
    output logic [31:0] o_copro_read_data,
    input  logic        i_fault,
    input  logic [7:0]  i_fault_status,
    input  logic [31:0] i_fault_address,
    input  logic        i_access_valid,
    input  logic        i_access_write,
    input  logic [31:0] i_access_address,
    output logic        o_access_cacheable,
    output logic        o_access_updateable,
    output logic        o_access_disruptive,
    output logic        o_cache_enable,
    output logic        o_cache_flush_req,
    input  logic        i_cache_flush_done,
    output logic        o_flush_busy
);

    localparam int NR       = 2 ** REGION_BITS;
    localparam int HI_SHIFT = REGION_SHIFT + REGION_BITS;

    logic [2:0]             cache_control;
    logic [NR-1:0]          cacheable;
    logic [NR-1:0]          updateable;
    logic [NR-1:0]          disruptive;
    logic                   wr;
    logic                   fifo_pop;
    logic [7:0]             head_status;
    logic [31:0]            head_address;
    logic [3:0]             fifo_count;
    logic                   fifo_overflow;
    logic [31:0]            rd_val;
    logic [REGION_BITS-1:0] idx;
    logic                   in_range;
    logic                   hit_c;
    logic                   hit_u;
    logic                   hit_d;
    logic                   trigger;
    flush_state_t           state;
    flush_state_t           state_n;
    logic                   pending;
    logic                   pending_n;

    assign wr       = !i_core_stall && (i_copro_operation == OP_MCR);
    assign fifo_pop = wr && (i_copro_crn == CRN_FPOP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_control <= '0;
            cacheable     <= '0;
            updateable    <= '0;
            disruptive    <= '0;
        end else if (wr) begin
            case (i_copro_crn)
                CRN_CACHE:      cache_control <= i_copro_write_data[2:0];
                CRN_CACHEABLE:  cacheable     <= i_copro_write_data[NR-1:0];
                CRN_UPDATEABLE: updateable    <= i_copro_write_data[NR-1:0];
                CRN_DISRUPTIVE: disruptive    <= i_copro_write_data[NR-1:0];
                default: ;
            endcase
        end
    end

    a25_fault_fifo #(
        .DEPTH (FAULT_DEPTH)
    ) u_fifo (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_push         (i_fault && !i_core_stall),
        .i_status       (i_fault_status),
        .i_address      (i_fault_address),
        .i_pop          (fifo_pop),
        .o_head_status  (head_status),
        .o_head_address (head_address),
        .o_count        (fifo_count),
        .o_overflow     (fifo_overflow)
    );

    always_comb begin
        rd_val = '0;
        case (i_copro_crn)
            CRN_ID:         rd_val = ID_VALUE;
            CRN_FLUSH:      rd_val = {31'd0, o_flush_busy};
            CRN_CACHE:      rd_val = {29'd0, cache_control};
            CRN_CACHEABLE:  rd_val = 32'(cacheable);
            CRN_UPDATEABLE: rd_val = 32'(updateable);
            CRN_DISRUPTIVE: rd_val = 32'(disruptive);
            CRN_FSTATUS:    rd_val = {fifo_overflow, 11'd0, fifo_count,
                                      8'd0, head_status};
            CRN_FADDR:      rd_val = head_address;
            default:        rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_copro_read_data <= '0;
        end else if (!i_core_stall) begin
            o_copro_read_data <= rd_val;
        end
    end

    // Addresses beyond the last region never hit anything
    assign idx      = i_access_address[REGION_SHIFT +: REGION_BITS];
    assign in_range = (i_access_address >> HI_SHIFT) == 32'd0;
    assign hit_c    = i_access_valid && in_range && cacheable[idx];
    assign hit_u    = i_access_valid && in_range && updateable[idx];
    assign hit_d    = i_access_valid && in_range && disruptive[idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_access_cacheable  <= 1'b0;
            o_access_updateable <= 1'b0;
            o_access_disruptive <= 1'b0;
        end else if (!i_core_stall) begin
            o_access_cacheable  <= hit_c;
            o_access_updateable <= hit_u;
            o_access_disruptive <= hit_d;
        end
    end

    assign trigger = (wr && (i_copro_crn == CRN_FLUSH))
                   || (!i_core_stall && i_access_write
                       && hit_d && cache_control[0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= FL_IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
        end
    end

    // Done is honoured even while stalled so the cache never waits on the core
    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            FL_IDLE: begin
                if (trigger) begin
                    state_n = FL_BUSY;
                end
            end
            FL_BUSY: begin
                if (i_cache_flush_done) begin
                    state_n   = (pending || trigger) ? FL_GAP : FL_IDLE;
                    pending_n = 1'b0;
                end else if (trigger) begin
                    pending_n = 1'b1;
                end
            end
            FL_GAP: begin
                if (!i_core_stall) begin
                    state_n = FL_BUSY;
                end
            end
            default: begin
                state_n   = FL_IDLE;
                pending_n = 1'b0;
            end
        endcase
    end

    assign o_cache_flush_req = (state == FL_BUSY);
    assign o_flush_busy      = (state != FL_IDLE);
    assign o_cache_enable    = cache_control[0];

endmodule

// File: tb/tb_a25_copro15_ext.sv
// Randomised and directed bench for a25_copro15_ext against a
// behavioural model of registers, fault queue and region lookup.
module tb_a25_copro15_ext;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_core_stall;
    logic [3:0]  i_copro_crn;
    logic [1:0]  i_copro_operation;
    logic [31:0] i_copro_write_data;
    logic [31:0] o_copro_read_data;
    logic        i_fault;
    logic [7:0]  i_fault_status;
    logic [31:0] i_fault_address;
    logic        i_access_valid;
    logic        i_access_write;
    logic [31:0] i_access_address;
    logic        o_access_cacheable;
    logic        o_access_updateable;
    logic        o_access_disruptive;
    logic        o_cache_enable;
    logic        o_cache_flush_req;
    logic        i_cache_flush_done;
    logic        o_flush_busy;

    a25_copro15_ext dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_core_stall        (i_core_stall),
        .i_copro_crn         (i_copro_crn),
        .i_copro_operation   (i_copro_operation),
        .i_copro_write_data  (i_copro_write_data),
        .o_copro_read_data   (o_copro_read_data),
        .i_fault             (i_fault),
        .i_fault_status      (i_fault_status),
        .i_fault_address     (i_fault_address),
        .i_access_valid      (i_access_valid),
        .i_access_write      (i_access_write),
        .i_access_address    (i_access_address),
        .o_access_cacheable  (o_access_cacheable),
        .o_access_updateable (o_access_updateable),
        .o_access_disruptive (o_access_disruptive),
        .o_cache_enable      (o_cache_enable),
        .o_cache_flush_req   (o_cache_flush_req),
        .i_cache_flush_done  (i_cache_flush_done),
        .o_flush_busy        (o_flush_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  st;
        logic [31:0] ad;
    } flt_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rgn [3];
    logic [2:0]  m_cc;
    logic        m_ovf;
    logic        m_busy;
    flt_t        m_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_rgn[i] = '0;
        m_cc   = '0;
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_q.delete();
    endtask

    task automatic m_pop();
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_ovf = 1'b0;
    endtask

    task automatic m_push(input logic [7:0] st, input logic [31:0] ad);
        flt_t f;
        f.st = st;
        f.ad = ad;
        if (m_q.size() < 4) m_q.push_back(f);
        else m_ovf = 1'b1;
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] crn);
        logic [7:0]  hs;
        logic [31:0] ha;
        logic [3:0]  cnt;
        hs  = (m_q.size() > 0) ? m_q[0].st : 8'd0;
        ha  = (m_q.size() > 0) ? m_q[0].ad : 32'd0;
        cnt = 4'(m_q.size());
        case (crn)
            4'd0:             return 32'h4156_0301;
            4'd1:             return {31'd0, m_busy};
            4'd2:             return {29'd0, m_cc};
            4'd3, 4'd4, 4'd5: return m_rgn[int'(crn) - 3];
            4'd6:             return {m_ovf, 11'd0, cnt, 8'd0, hs};
            4'd7:             return ha;
            default:          return 32'd0;
        endcase
    endfunction

    task automatic cp_write(input logic [3:0] crn, input logic [31:0] wd);
        i_copro_crn        = crn;
        i_copro_operation  = 2'd2;
        i_copro_write_data = wd;
        @(negedge i_clk);
        i_copro_operation  = 2'd0;
        case (crn)
            4'd2:             m_cc = wd[2:0];
            4'd3, 4'd4, 4'd5: m_rgn[int'(crn) - 3] = wd;
            4'd8:             m_pop();
            default: ;
        endcase
    endtask

    task automatic cp_read(input logic [3:0] crn, input string tag);
        i_copro_crn       = crn;
        i_copro_operation = 2'd0;
        @(negedge i_clk);
        check(tag, o_copro_read_data, exp_read(crn));
    endtask

    task automatic fault_op(input logic push, input logic pop,
                            input logic [7:0] st, input logic [31:0] ad);
        i_fault         = push;
        i_fault_status  = st;
        i_fault_address = ad;
        if (pop) begin
            i_copro_crn       = 4'd8;
            i_copro_operation = 2'd2;
        end
        @(negedge i_clk);
        i_fault           = 1'b0;
        i_copro_operation = 2'd0;
        if (pop) m_pop();
        if (push) m_push(st, ad);
    endtask

    task automatic lookup(input logic [31:0] addr, input logic valid,
                          input logic wr, input string tag);
        int         idx;
        logic       inr;
        logic [2:0] e;
        i_access_address = addr;
        i_access_valid   = valid;
        i_access_write   = wr;
        @(negedge i_clk);
        i_access_valid = 1'b0;
        i_access_write = 1'b0;
        idx = int'((addr / 32'h0020_0000) % 32);
        inr = (addr / 32'h0400_0000) == 0;
        e   = '0;
        if (valid && inr) begin
            e[0] = m_rgn[0][idx];
            e[1] = m_rgn[1][idx];
            e[2] = m_rgn[2][idx];
        end
        check(tag, {29'd0, o_access_disruptive, o_access_updateable,
                    o_access_cacheable}, {29'd0, e});
    endtask

    task automatic pulse_done();
        i_cache_flush_done = 1'b1;
        @(negedge i_clk);
        i_cache_flush_done = 1'b0;
    endtask

    initial begin
        i_rst_n            = 1'b0;
        i_core_stall       = 1'b0;
        i_copro_crn        = '0;
        i_copro_operation  = '0;
        i_copro_write_data = '0;
        i_fault            = 1'b0;
        i_fault_status     = '0;
        i_fault_address    = '0;
        i_access_valid     = 1'b0;
        i_access_write     = 1'b0;
        i_access_address   = '0;
        i_cache_flush_done = 1'b0;
        m_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        cp_read(4'd0, "rd_id");
        check("rd_id_lit", o_copro_read_data, 32'h4156_0301);
        cp_read(4'd2, "rd_cc_rst");
        cp_read(4'd7, "rd_faddr_rst");
        check("req_rst", {31'd0, o_cache_flush_req}, 32'd0);
        check("busy_rst", {31'd0, o_flush_busy}, 32'd0);

        cp_write(4'd3, 32'h0000_0005);
        lookup(32'h0040_0000, 1'b1, 1'b0, "lk_idx2");
        check("lk_idx2_c", {31'd0, o_access_cacheable}, 32'd1);
        lookup(32'h0020_0000, 1'b1, 1'b0, "lk_idx1");
        lookup(32'h4000_0000, 1'b1, 1'b0, "lk_high");
        lookup(32'h0040_0000, 1'b0, 1'b0, "lk_invalid");

        for (int i = 1; i <= 5; i++) fault_op(1'b1, 1'b0, 8'(i), $urandom());
        cp_read(4'd6, "fifo_ovf");
        check("fifo_ovf_lit", o_copro_read_data, 32'h8004_0001);
        fault_op(1'b0, 1'b1, 8'd0, 32'd0);
        cp_read(4'd6, "fifo_pop1");
        for (int i = 0; i < 4; i++) fault_op(1'b0, 1'b1, 8'd0, 32'd0);
        cp_read(4'd6, "fifo_empty_st");
        cp_read(4'd7, "fifo_empty_ad");

        for (int i = 0; i < 4; i++)
            fault_op(1'b1, 1'b0, 8'($urandom()), $urandom());
        fault_op(1'b1, 1'b1, 8'hAA, 32'hDEAD_BEEF);
        cp_read(4'd6, "fifo_pushpop_st");
        cp_read(4'd7, "fifo_pushpop_ad");

        repeat (300) begin
            case ($urandom_range(0, 4))
                0: cp_write(4'($urandom_range(2, 15)), $urandom());
                1: lookup((($urandom_range(0, 3) != 0) ?
                           ($urandom() & 32'h03FF_FFFF) : $urandom()),
                          1'($urandom_range(0, 3) != 0), 1'b0, "rnd_lookup");
                2: fault_op(1'($urandom()), 1'($urandom()),
                            8'($urandom()), $urandom());
                3: cp_read(4'($urandom_range(0, 15)), "rnd_read");
                default: begin
                    i_core_stall       = 1'b1;
                    i_copro_crn        = 4'($urandom_range(2, 8));
                    i_copro_operation  = 2'd2;
                    i_copro_write_data = $urandom();
                    i_fault            = 1'b1;
                    @(negedge i_clk);
                    i_core_stall      = 1'b0;
                    i_copro_operation = 2'd0;
                    i_fault           = 1'b0;
                end
            endcase
        end
        cp_read(4'd6, "rnd_final_st");

        cp_write(4'd2, 32'd0);
        cp_write(4'd1, 32'd0);
        check("fl_req", {31'd0, o_cache_flush_req}, 32'd1);
        check("fl_busy", {31'd0, o_flush_busy}, 32'd1);
        m_busy = 1'b1;
        cp_read(4'd1, "fl_rd_busy");
        cp_write(4'd1, 32'd0);
        check("fl_req_pend", {31'd0, o_cache_flush_req}, 32'd1);
        pulse_done();
        check("fl_gap", {31'd0, o_cache_flush_req}, 32'd0);
        @(negedge i_clk);
        check("fl_rebusy", {31'd0, o_cache_flush_req}, 32'd1);
        pulse_done();
        check("fl_idle_req", {31'd0, o_cache_flush_req}, 32'd0);
        check("fl_idle_busy", {31'd0, o_flush_busy}, 32'd0);
        m_busy = 1'b0;
        cp_read(4'd1, "fl_rd_idle");

        cp_write(4'd2, 32'd1);
        check("cache_en", {31'd0, o_cache_enable}, 32'd1);
        cp_write(4'd5, 32'd1);
        lookup(32'h0000_1000, 1'b1, 1'b1, "dis_lookup");
        check("dis_trig", {31'd0, o_cache_flush_req}, 32'd1);
        pulse_done();
        check("dis_done", {31'd0, o_flush_busy}, 32'd0);
        cp_write(4'd2, 32'd0);
        lookup(32'h0000_1000, 1'b1, 1'b1, "dis_off_lookup");
        check("dis_off", {31'd0, o_cache_flush_req}, 32'd0);

        cp_write(4'd2, 32'd1);
        i_core_stall     = 1'b1;
        i_access_valid   = 1'b1;
        i_access_write   = 1'b1;
        i_access_address = 32'h0000_1000;
        i_fault          = 1'b1;
        @(negedge i_clk);
        i_core_stall   = 1'b0;
        i_access_valid = 1'b0;
        i_access_write = 1'b0;
        i_fault        = 1'b0;
        check("stall_notrig", {31'd0, o_flush_busy}, 32'd0);
        cp_read(4'd6, "stall_nopush");
        cp_write(4'd1, 32'd0);
        i_core_stall = 1'b1;
        pulse_done();
        check("stall_done", {31'd0, o_flush_busy}, 32'd0);
        i_core_stall = 1'b0;

        cp_write(4'd1, 32'd0);
        check("rst_pre", {31'd0, o_cache_flush_req}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_async_req", {31'd0, o_cache_flush_req}, 32'd0);
        check("rst_async_busy", {31'd0, o_flush_busy}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_reset();
        pulse_done();
        check("rst_late_done", {31'd0, o_cache_flush_req}, 32'd0);
        cp_read(4'd3, "rst_rgn");
        cp_read(4'd6, "rst_fifo");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
